regfile_index_encoder: RTL and testbench



---
 rtl/regfile_index_encoder_if.sv | 27 ++
 rtl/regfile_index_encoder.sv | 122 ++++++++++++
 tb/tb_regfile_index_encoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_index_encoder_if.sv
// Handshake bundle for the regfile index encoder: vector in, index beats out.
// The master drives vectors and consumes beats; the slave is the encoder.
interface regfile_index_encoder_if #(
  parameter int IDX_W = 5
);
  localparam int N = 2**IDX_W;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic [IDX_W:0]   remaining;
  logic             empty_drop;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_index, out_last, remaining, empty_drop
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_index, out_last, remaining, empty_drop
  );
endinterface

// File: rtl/regfile_index_encoder.sv
// Turns a multi-hot register mask into a serial stream of register numbers,
// lowest first, one per accepted beat.
module regfile_index_encoder #(
  parameter int IDX_W     = 5,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                   clock,
  input  logic                   ctrl_reset_n,
  regfile_index_encoder_if.slave bus
);
  localparam int N     = 2**IDX_W;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {IDLE, EMIT} state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
    logic             last;
    logic [CNT_W-1:0] remaining;
  } beat_t;

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             empty_drop_q, empty_drop_d;

  logic [N-1:0]     masked;
  logic [CNT_W-1:0] masked_cnt;
  logic [IDX_W-1:0] low_idx;
  logic             accept;
  logic             emitting;
  logic             last;
  beat_t            beat;

  // Register 0 is hardwired zero, so it never counts as a pending write.
  always_comb begin
    masked = bus.in_vec;
    if (SKIP_ZERO) masked[0] = 1'b0;
  end

  always_comb begin
    masked_cnt = '0;
    for (int i = 0; i < N; i++) masked_cnt = masked_cnt + CNT_W'(masked[i]);
  end

  always_comb begin
    low_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDX_W'(i);
    end
  end

  assign emitting = (state_q == EMIT);
  assign last     = (remaining_q == CNT_W'(1));
  // Ready is gated by reset so nothing is offered while the block is held.
  assign accept   = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    remaining_d  = remaining_q;
    empty_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (masked != '0) begin
            pending_d   = masked;
            remaining_d = masked_cnt;
            state_d     = EMIT;
          end else begin
            empty_drop_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          // x & (x-1) drops the lowest set bit, i.e. the index just emitted.
          pending_d   = pending_q & (pending_q - N'(1));
          remaining_d = remaining_q - CNT_W'(1);
          if (last) begin
            state_d     = IDLE;
            pending_d   = '0;
            remaining_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      remaining_q  <= '0;
      empty_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      remaining_q  <= remaining_d;
      empty_drop_q <= empty_drop_d;
    end
  end

  always_comb begin
    beat = '0;
    if (emitting) begin
      beat.valid     = 1'b1;
      beat.index     = low_idx;
      beat.last      = last;
      beat.remaining = remaining_q;
    end
  end

  assign bus.in_ready   = (state_q == IDLE) & ctrl_reset_n;
  assign bus.out_valid  = beat.valid;
  assign bus.out_index  = beat.index;
  assign bus.out_last   = beat.last;
  assign bus.remaining  = beat.remaining;
  assign bus.empty_drop = empty_drop_q;
endmodule

// File: tb/tb_regfile_index_encoder.sv
// Directed and randomized check of regfile_index_encoder against a
// bit-scan reference model of the emitted index sequence.
module tb_regfile_index_encoder;
  logic clock = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  regfile_index_encoder_if #(.IDX_W(5)) bus ();

  regfile_index_encoder #(.IDX_W(5), .SKIP_ZERO(1'b1)) dut (
    .clock        (clock),
    .ctrl_reset_n (rst_n),
    .bus          (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_index"}, 32'(bus.out_index), 32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_remaining"}, 32'(bus.remaining), 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: the list of register numbers to emit, ascending, reg 0 excluded.
  function automatic void model(input logic [31:0] vec, output int q[$]);
    q = {};
    for (int i = 1; i < 32; i++) if (vec[i]) q.push_back(i);
  endfunction

  // Offers vec from IDLE, holds out_ready low for `hold` cycles on the first
  // beat, then drains with random backpressure of bp_pct percent.
  task automatic send(input logic [31:0] vec, input int hold, input int bp_pct);
    int q[$];
    int j;
    int guard;
    bit rdy;
    model(vec, q);
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_vec    = vec;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    step();
    bus.in_valid = 1'b0;
    bus.in_vec   = $urandom;
    if (q.size() == 0) begin
      chk("drop_pulse", 32'(bus.empty_drop), 32'd1);
      chk("drop_ready", 32'(bus.in_ready), 32'd1);
      chk_quiet("drop");
      step();
      chk("drop_end", 32'(bus.empty_drop), 32'd0);
      chk("drop_ready2", 32'(bus.in_ready), 32'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_index", 32'(bus.out_index), 32'(q[0]));
      chk("hold_rem",   32'(bus.remaining), 32'(q.size()));
      chk("hold_ready", 32'(bus.in_ready),  32'd0);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_vec    = $urandom;
      step();
    end
    j = 0;
    guard = 0;
    while (j < q.size() && guard < 2000) begin
      chk("beat_valid", 32'(bus.out_valid), 32'd1);
      chk("beat_index", 32'(bus.out_index), 32'(q[j]));
      chk("beat_rem",   32'(bus.remaining), 32'(q.size() - j));
      chk("beat_last",  32'(bus.out_last),  32'(j == q.size() - 1));
      chk("beat_ready", 32'(bus.in_ready),  32'd0);
      chk("beat_drop",  32'(bus.empty_drop), 32'd0);
      rdy = ($urandom_range(99) >= 32'(bp_pct));
      bus.out_ready = rdy;
      bus.in_valid  = 1'($urandom_range(1));
      bus.in_vec    = $urandom;
      step();
      if (rdy) j++;
      guard++;
    end
    chk("drain_bound", 32'(guard < 2000), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk_quiet("after");
    chk("after_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b1;

    repeat (4) begin
      bus.in_valid  = 1'($urandom_range(1));
      bus.in_vec    = $urandom;
      bus.out_ready = 1'($urandom_range(1));
      step();
      chk_quiet("reset");
      chk("reset_ready", 32'(bus.in_ready),   32'd0);
      chk("reset_drop",  32'(bus.empty_drop), 32'd0);
    end
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("release_ready", 32'(bus.in_ready), 32'd1);
    chk_quiet("release");

    send(32'h0000_0400, 0, 0);
    send(32'h8000_0012, 0, 0);
    send(32'h0000_0001, 0, 0);
    send(32'h0000_0000, 0, 0);
    send(32'hFFFF_FFFF, 0, 0);
    send(32'h0000_0006, 3, 0);
    send(32'h8000_0000, 0, 0);

    // Abort mid-vector: index 4 and 5 go out, then reset while 6 is offered.
    bus.in_vec    = 32'h0000_00F0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("abort_idx4", 32'(bus.out_index), 32'd4);
    step();
    chk("abort_idx5", 32'(bus.out_index), 32'd5);
    step();
    chk("abort_idx6", 32'(bus.out_index), 32'd6);
    chk("abort_rem6", 32'(bus.remaining), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("abort_async");
    chk("abort_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) begin
      step();
      chk_quiet("abort_hold");
    end
    rst_n = 1'b1;
    step();
    chk_quiet("abort_release");
    send(32'h0000_0008, 0, 0);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] v;
      case (n % 3)
        0:       v = $urandom;
        1:       v = $urandom & $urandom & $urandom;
        default: v = 32'(1) << $urandom_range(31);
      endcase
      send(v, $urandom_range(2), $urandom_range(50));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
